// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply, restoring divide, signed or unsigned.
// Latency: WIDTH+2 cycles from the accepting edge to done (2 cycles for divide by zero).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic               is_div, neg_p, neg_r, dz;
    logic [WIDTH-1:0]   amag, bmag;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic               last_iter;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        a_abs     = (op[0] && A[WIDTH-1]) ? -A : A;
        b_abs     = (op[0] && B[WIDTH-1]) ? -B : B;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, amag} : '0);
        // Borrow out of the top bit means the trial subtract failed and the remainder is restored.
        div_trial = {rem, acc[WIDTH-1]} - {2'b00, bmag};
        last_iter = (cnt == CNT_W'(WIDTH - 1));
        prod_fix  = neg_p ? -acc : acc;
        fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo    = prod_fix[WIDTH-1:0];
        if (dz) begin
            fix_hi = neg_r ? -amag : amag;
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            fix_lo = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: if (start) state_nxt = (op[1] && (B == '0)) ? FIX : CALC;
            CALC: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            amag     <= '0;
            bmag     <= '0;
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
            HI       <= '0;
            LO       <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    is_div <= op[1];
                    neg_p  <= op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_r  <= op[0] & A[WIDTH-1];
                    dz     <= op[1] && (B == '0);
                    amag   <= a_abs;
                    bmag   <= b_abs;
                    // Low half holds the multiplier for multiply, the dividend/quotient for divide.
                    acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                    rem    <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!is_div) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_trial[WIDTH+1]};
                        rem <= div_trial[WIDTH+1] ? {rem[WIDTH-1:0], acc[WIDTH-1]}
                                                  : div_trial[WIDTH:0];
                    end
                end
                FIX: begin
                    HI       <= fix_hi;
                    LO       <= fix_lo;
                    div_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule
